// File: rtl/alu_operand_stage_pkg.sv
// Shared ALU definitions: op codes and operand-2 select codes used by decode and the operand stage.
package alu_operand_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_PASS = 4'd11
    } alu_op_e;

    localparam logic OP2_REG = 1'b0;
    localparam logic OP2_IMM = 1'b1;

endpackage

// File: rtl/alu_operand_stage_fwd_unit.sv
// Per-source-register bypass select (EX/MEM over MEM/WB over held data) and load-use compare.
module fwd_unit #(
    parameter int XLEN = 32
) (
    input  logic [4:0]      rs,
    input  logic [XLEN-1:0] rs_data,
    input  logic            check,
    input  logic            exm_rd_we,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            exm_is_load,
    input  logic            wb_rd_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data,
    output logic            load_use
);

    logic exm_hit;
    logic wb_hit;

    always_comb begin
        exm_hit  = exm_rd_we && (exm_rd == rs) && (rs != 5'd0);
        wb_hit   = wb_rd_we && (wb_rd == rs) && (rs != 5'd0);
        data     = rs_data;
        // A load in EX/MEM has no data yet; it stalls instead of forwarding.
        if (exm_hit && !exm_is_load) begin
            data = exm_result;
        end else if (wb_hit) begin
            data = wb_data;
        end
        load_use = check && exm_hit && exm_is_load;
    end

endmodule

// File: rtl/alu_operand_stage.sv
// Single-entry operand register between decode and the ALU, with bypass muxing and load-use stall.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_alu_type,
    input  logic            in_op2_sel,
    input  logic [4:0]      in_rs1,
    input  logic [4:0]      in_rs2,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_we,
    input  logic            exm_rd_we,
    input  logic [4:0]      exm_rd,
    input  logic [XLEN-1:0] exm_result,
    input  logic            exm_is_load,
    input  logic            wb_rd_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_type,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [4:0]      out_rd,
    output logic            out_rd_we
);

    logic            held_valid;
    logic [3:0]      held_alu_type;
    logic            held_op2_sel;
    logic [4:0]      held_rs1;
    logic [4:0]      held_rs2;
    logic [XLEN-1:0] held_rs1_data;
    logic [XLEN-1:0] held_rs2_data;
    logic [XLEN-1:0] held_imm;
    logic [4:0]      held_rd;
    logic            held_rd_we;

    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;
    logic            rs1_load_use;
    logic            rs2_load_use;
    logic            hazard;
    logic            capture;
    logic            fire;

    fwd_unit #(.XLEN(XLEN)) u_fwd_rs1 (
        .rs          (held_rs1),
        .rs_data     (held_rs1_data),
        .check       (1'b1),
        .exm_rd_we   (exm_rd_we),
        .exm_rd      (exm_rd),
        .exm_result  (exm_result),
        .exm_is_load (exm_is_load),
        .wb_rd_we    (wb_rd_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .data        (rs1_fwd),
        .load_use    (rs1_load_use)
    );

    // rs2 only matters for the hazard when the ALU actually reads it.
    fwd_unit #(.XLEN(XLEN)) u_fwd_rs2 (
        .rs          (held_rs2),
        .rs_data     (held_rs2_data),
        .check       (held_op2_sel == OP2_REG),
        .exm_rd_we   (exm_rd_we),
        .exm_rd      (exm_rd),
        .exm_result  (exm_result),
        .exm_is_load (exm_is_load),
        .wb_rd_we    (wb_rd_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .data        (rs2_fwd),
        .load_use    (rs2_load_use)
    );

    assign hazard    = held_valid && (rs1_load_use || rs2_load_use);
    assign out_valid = held_valid && !hazard;
    assign fire      = out_valid && out_ready;
    assign in_ready  = !held_valid || fire;
    assign capture   = in_valid && in_ready;

    assign op1       = rs1_fwd;
    assign op2       = (held_op2_sel == OP2_IMM) ? held_imm : rs2_fwd;
    assign alu_type  = held_alu_type;
    assign out_rd    = held_rd;
    assign out_rd_we = held_rd_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_valid    <= 1'b0;
            held_alu_type <= '0;
            held_op2_sel  <= 1'b0;
            held_rs1      <= '0;
            held_rs2      <= '0;
            held_rs1_data <= '0;
            held_rs2_data <= '0;
            held_imm      <= '0;
            held_rd       <= '0;
            held_rd_we    <= 1'b0;
        end else begin
            if (flush) begin
                held_valid <= 1'b0;
            end else if (capture) begin
                held_valid <= 1'b1;
            end else if (fire) begin
                held_valid <= 1'b0;
            end
            if (capture && !flush) begin
                held_alu_type <= in_alu_type;
                held_op2_sel  <= in_op2_sel;
                held_rs1      <= in_rs1;
                held_rs2      <= in_rs2;
                held_rs1_data <= in_rs1_data;
                held_rs2_data <= in_rs2_data;
                held_imm      <= in_imm;
                held_rd       <= in_rd;
                held_rd_we    <= in_rd_we;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Randomized and directed checks of alu_operand_stage against an instruction-slot reference model.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_alu_type;
    logic            in_op2_sel;
    logic [4:0]      in_rs1, in_rs2;
    logic [XLEN-1:0] in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]      in_rd;
    logic            in_rd_we;
    logic            exm_rd_we;
    logic [4:0]      exm_rd;
    logic [XLEN-1:0] exm_result;
    logic            exm_is_load;
    logic            wb_rd_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      alu_type;
    logic [XLEN-1:0] op1, op2;
    logic [4:0]      out_rd;
    logic            out_rd_we;

    int n_total = 0;
    int n_bad   = 0;

    typedef struct {
        bit              valid;
        logic [3:0]      alu_type;
        logic            imm_sel;
        logic [4:0]      rs1, rs2;
        logic [XLEN-1:0] rs1_data, rs2_data, imm;
        logic [4:0]      rd;
        logic            rd_we;
    } slot_t;

    slot_t slot;

    always #5 clk = ~clk;

    alu_operand_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_type(in_alu_type), .in_op2_sel(in_op2_sel),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rd(in_rd), .in_rd_we(in_rd_we),
        .exm_rd_we(exm_rd_we), .exm_rd(exm_rd), .exm_result(exm_result), .exm_is_load(exm_is_load),
        .wb_rd_we(wb_rd_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_type(alu_type), .op1(op1), .op2(op2), .out_rd(out_rd), .out_rd_we(out_rd_we)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Value the ALU should see for a source register, from the current writer buses.
    function automatic logic [XLEN-1:0] src_value(input logic [4:0] rs, input logic [XLEN-1:0] regval);
        if (rs == 0) return regval;
        if (exm_rd_we && exm_rd == rs && !exm_is_load) return exm_result;
        if (wb_rd_we && wb_rd == rs) return wb_data;
        return regval;
    endfunction

    function automatic bit waits_on_load();
        if (!slot.valid || !exm_is_load || !exm_rd_we || exm_rd == 0) return 0;
        return (exm_rd == slot.rs1) || (!slot.imm_sel && exm_rd == slot.rs2);
    endfunction

    task automatic idle_inputs();
        in_valid = 0; in_alu_type = 0; in_op2_sel = 0; in_rs1 = 0; in_rs2 = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_rd = 0; in_rd_we = 0;
        exm_rd_we = 0; exm_rd = 0; exm_result = 0; exm_is_load = 0;
        wb_rd_we = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
    endtask

    task automatic offer(input logic [3:0] op, input logic imm_sel,
                         input logic [4:0] rs1, input logic [XLEN-1:0] d1,
                         input logic [4:0] rs2, input logic [XLEN-1:0] d2,
                         input logic [XLEN-1:0] imm, input logic [4:0] rd);
        in_valid = 1; in_alu_type = op; in_op2_sel = imm_sel;
        in_rs1 = rs1; in_rs1_data = d1; in_rs2 = rs2; in_rs2_data = d2;
        in_imm = imm; in_rd = rd; in_rd_we = (rd != 0);
    endtask

    task automatic rand_inputs();
        logic [4:0] r1, r2;
        r1 = 5'($urandom_range(0, 7));
        r2 = 5'($urandom_range(0, 7));
        offer(4'($urandom_range(0, 11)), 1'($urandom_range(0, 1)),
              r1, (r1 == 0) ? '0 : $urandom, r2, (r2 == 0) ? '0 : $urandom,
              $urandom, 5'($urandom_range(0, 7)));
        in_valid    = 1'($urandom_range(0, 1));
        exm_rd_we   = 1'($urandom_range(0, 1));
        exm_rd      = 5'($urandom_range(0, 7));
        exm_result  = $urandom;
        exm_is_load = ($urandom_range(0, 3) == 0);
        wb_rd_we    = 1'($urandom_range(0, 1));
        wb_rd       = 5'($urandom_range(0, 7));
        wb_data     = $urandom;
        flush       = ($urandom_range(0, 15) == 0);
        out_ready   = ($urandom_range(0, 3) != 0);
    endtask

    // One clock: check outputs at the falling edge, then advance the model over the rising edge.
    task automatic step();
        bit    exp_ov, exp_ir;
        slot_t nxt;
        @(negedge clk);
        exp_ov = slot.valid && !waits_on_load();
        exp_ir = !slot.valid || (exp_ov && out_ready);
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, exp_ir);
        if (slot.valid) begin
            chk("op1", op1, src_value(slot.rs1, slot.rs1_data));
            chk("op2", op2, slot.imm_sel ? slot.imm : src_value(slot.rs2, slot.rs2_data));
            chk("alu_type", alu_type, slot.alu_type);
            chk("out_rd", out_rd, slot.rd);
            chk("out_rd_we", out_rd_we, slot.rd_we);
        end
        nxt = slot;
        if (flush) begin
            nxt.valid = 0;
        end else if (in_valid && exp_ir) begin
            nxt = '{1, in_alu_type, in_op2_sel, in_rs1, in_rs2, in_rs1_data,
                    in_rs2_data, in_imm, in_rd, in_rd_we};
        end else if (exp_ov && out_ready) begin
            nxt.valid = 0;
        end
        @(posedge clk);
        #1;
        slot = nxt;
    endtask

    initial begin
        slot = '{default: '0};
        idle_inputs();
        rst = 1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op1", op1, 0);
        chk("rst_op2", op2, 0);
        chk("rst_alu_type", alu_type, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_rd_we", out_rd_we, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // ADD x1(=5) + imm 7, no bypass
        offer(ALU_ADD, OP2_IMM, 5'd1, 32'd5, 5'd0, 32'd0, 32'd7, 5'd2);
        step();
        in_valid = 0;
        #1;
        chk("s1_out_valid", out_valid, 1);
        chk("s1_op1", op1, 32'd5);
        chk("s1_op2", op2, 32'd7);
        step();

        // EX/MEM beats MEM/WB for the same register
        offer(ALU_SUB, OP2_REG, 5'd3, 32'h1, 5'd0, 32'd0, 32'd0, 5'd5);
        step();
        in_valid = 0; out_ready = 0;
        exm_rd_we = 1; exm_rd = 5'd3; exm_result = 32'h10;
        wb_rd_we = 1; wb_rd = 5'd3; wb_data = 32'h20;
        #1;
        chk("s2_op1_exm_priority", op1, 32'h10);
        // x0 never forwards
        wb_rd = 5'd0; wb_data = 32'hFF;
        #1;
        chk("s3_op2_x0", op2, 32'd0);
        step();
        idle_inputs();
        step();

        // Load-use on rs1, cleared next cycle by the MEM/WB copy
        offer(ALU_OR, OP2_IMM, 5'd4, 32'd1, 5'd0, 32'd0, 32'd3, 5'd6);
        step();
        in_valid = 1; in_rs1 = 5'd7; in_rs1_data = 32'd77;
        exm_is_load = 1; exm_rd_we = 1; exm_rd = 5'd4; exm_result = 32'hDEAD;
        #1;
        chk("s4_hazard_out_valid", out_valid, 0);
        chk("s4_hazard_in_ready", in_ready, 0);
        step();
        exm_is_load = 0; exm_rd_we = 0;
        wb_rd_we = 1; wb_rd = 5'd4; wb_data = 32'd9;
        in_valid = 0;
        #1;
        chk("s4_clear_out_valid", out_valid, 1);
        chk("s4_clear_op1", op1, 32'd9);
        step();
        idle_inputs();

        // Downstream stall for 3 cycles with a new offer waiting
        offer(ALU_AND, OP2_REG, 5'd1, 32'hA, 5'd2, 32'hB, 32'd0, 5'd3);
        step();
        out_ready = 0;
        offer(ALU_XOR, OP2_IMM, 5'd5, 32'h55, 5'd0, 32'd0, 32'h66, 5'd7);
        repeat (3) step();
        chk("s5_stall_op1", op1, 32'hA);
        out_ready = 1;
        step();
        in_valid = 0;
        #1;
        chk("s5_new_captured", op1, 32'h55);

        // Flush beats a simultaneous capture
        flush = 1;
        offer(ALU_ADD, OP2_IMM, 5'd1, 32'd1, 5'd0, 32'd0, 32'd1, 5'd1);
        step();
        flush = 0; in_valid = 0;
        #1;
        chk("s6_flush_out_valid", out_valid, 0);
        step();

        // Reset in the middle of a stall drops the instruction immediately
        offer(ALU_SLL, OP2_IMM, 5'd2, 32'h12, 5'd0, 32'd0, 32'h2, 5'd4);
        out_ready = 0;
        step();
        in_valid = 0;
        step();
        rst = 1;
        #1;
        chk("s7_rst_out_valid", out_valid, 0);
        chk("s7_rst_op1", op1, 0);
        slot = '{default: '0};
        #2 rst = 0;
        idle_inputs();
        step();

        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
